frame_transmitter: RTL and testbench
====================================

// Module: frame_transmitter
// PURPOSE
//  Transmit-side framer and serializer: the producer of the framed serial stream that the
//  receiver chain decodes. Takes a frame length and payload bytes over valid/ready.
//  Emits one NRZ bit every CLKS_PER_BIT clocks, MSB first, in this order:
//  PREAMBLE, SYNC, LEN, PAYLOAD, CRC, then an idle GAP.
//  Sits between the transmitter data source and the modulator/channel model in system.
// PARAMETERS
//  CLKS_PER_BIT   4       clocks per transmitted bit; must be >= 2
//  PREAMBLE_BITS  16      alternating 1,0,1,0... bits, starting with 1
//  SYNC_WORD      16'hD391  sync pattern, sent MSB first
//  GAP_BITS       8       idle bit periods (data_o=0) after CRC before returning to IDLE
//  MAX_LEN        255     largest accepted payload length in bytes (len_i is 8 bits)
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous, active-high reset
//  start_i        in   1  request a frame; accepted when start_i && start_ready_o
//  len_i          in   8  payload length, sampled on start; valid range 1..MAX_LEN
//  start_ready_o  out  1  high only in IDLE
//  byte_i         in   8  payload byte
//  byte_valid_i   in   1  byte_i valid
//  byte_ready_o   out  1  holding register empty and payload bytes still owed
//  data_o         out  1  serial line bit
//  bit_strobe_o   out  1  one-cycle pulse on the clock where data_o takes a new bit
//  tx_active_o    out  1  high from the first preamble bit through the last GAP bit
//  frame_done_o   out  1  one-cycle pulse on the clock the FSM re-enters IDLE
//  underrun_o     out  1  sticky: a payload byte was missing at its boundary; cleared on next start
// BEHAVIOUR
//  Reset: all outputs 0 except start_ready_o=1; FSM=IDLE; counters and CRC cleared;
//   holding register empty. Reset takes effect mid-frame: the line drops to 0 on the next edge.
//  FSM states: IDLE, PREAMBLE, SYNC, LEN, PAYLOAD, CRC, GAP.
//   Each state ends after its bit count: PREAMBLE_BITS, 16, 8, 8*len, 8, GAP_BITS.
//  Start handling:
//   - start with len_i==0 is ignored: FSM stays in IDLE and no flag is set.
//   - A valid start latches len and clears CRC (init 8'h00) and underrun_o.
//   - It sets the baud counter to 0; next cycle: state=PREAMBLE, first bit driven, bit_strobe_o=1.
//  Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. On wrap the next bit is loaded
//   and bit_strobe_o pulses. Each bit is therefore held for exactly CLKS_PER_BIT clocks.
//  Handshake:
//   - byte_ready_o is high in LEN or PAYLOAD while the holding register is empty
//     and fewer than len bytes have been fetched.
//   - A transfer occurs on byte_valid_i && byte_ready_o. Only one byte is buffered.
//   - A byte fetched during LEN serves as the first payload byte.
//  Underrun: at a payload byte boundary with the holding register empty:
//   - 8'h00 is sent in place of the missing byte and is included in the CRC;
//   - underrun_o is set and that byte counts as fetched.
//  CRC: CRC-8, poly x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
//   Computed over the LEN byte and the payload bytes, one bit per strobe.
//   The CRC byte is sent MSB first.
//  Timing:
//   - Total frame = PREAMBLE_BITS+16+8+8*len+8 bits, followed by GAP_BITS of 0.
//   - tx_active_o falls, and frame_done_o and start_ready_o rise, on the same clock.
//   - Earliest next start: that same clock (back-to-back frames allowed).
//  Other boundaries:
//   - start_i while busy is ignored.
//   - byte_valid_i outside LEN/PAYLOAD is ignored.
//   - len=255 needs an 8-bit fetch counter plus a 9-bit state compare, with no wrap.
// TESTING
//  T1 CLKS_PER_BIT=4, len=1, byte 0xA5 given early:
//     preamble 1010.., sync D391, 0x01, 0xA5, CRC 0x67.
//     56 bits = 224 clks, then 32 gap clks; frame_done_o pulses once.
//  T2 Bit timing: every bit_strobe_o exactly 4 clks apart.
//     data_o is stable between strobes; tx_active_o is high for 256 clks.
//  T3 len=3, byte_valid_i withheld for the 2nd byte:
//     0x00 is sent in its place, underrun_o=1, and the CRC matches {03,b0,00,b2}.
//  T4 start with len=0 -> no activity; start_i asserted during frame -> ignored.
//  T5 rst asserted mid-PAYLOAD:
//     next edge data_o=0, tx_active_o=0, start_ready_o=1; a new start sends a clean frame.
//  T6 Back-to-back starts with len=255 and random bytes with random valid gaps:
//     the scoreboard deserializes and checks sync, len, bytes and CRC.

Source files
------------

// File: rtl/frame_transmitter.sv
// Transmit-side framer and NRZ serializer: preamble, sync word, length, payload,
// CRC-8 and an idle gap, one bit every CLKS_PER_BIT clocks, MSB first.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | line low, waiting for a start with len 1..MAX_LEN
// PREAMBLE | alternating 1,0,... bits
// SYNC     | SYNC_WORD, MSB first
// LEN      | length byte; first payload byte may be fetched
// PAYLOAD  | 8*len payload bits, 8'h00 substituted on underrun
// CRC      | CRC-8 of LEN and payload bytes
// GAP      | GAP_BITS idle bit periods, line low
module frame_transmitter #(
  parameter int unsigned CLKS_PER_BIT  = 4,
  parameter int unsigned PREAMBLE_BITS = 16,
  parameter logic [15:0] SYNC_WORD     = 16'hD391,
  parameter int unsigned GAP_BITS      = 8,
  parameter int unsigned MAX_LEN       = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] len_i,
  output logic       start_ready_o,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  output logic       byte_ready_o,
  output logic       data_o,
  output logic       bit_strobe_o,
  output logic       tx_active_o,
  output logic       frame_done_o,
  output logic       underrun_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SYNC,
    S_LEN,
    S_PAYLOAD,
    S_CRC,
    S_GAP
  } state_t;

  localparam int unsigned    BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [15:0]    PRE_LAST  = 16'(PREAMBLE_BITS - 1);
  localparam logic [15:0]    GAP_LAST  = 16'(GAP_BITS - 1);
  localparam logic [8:0]     MAX_LEN9  = 9'(MAX_LEN);

  state_t            state_q, state_nxt;
  logic [BAUD_W-1:0] baud_q;
  logic [15:0]       bits_left_q, bits_nxt;
  logic [7:0]        len_q;
  logic [7:0]        fetch_q;
  logic [7:0]        hold_q;
  logic              hold_full_q;
  logic [7:0]        cur_byte_q, cur_byte_nxt;
  logic [7:0]        crc_q;
  logic              data_q, strobe_q, done_q, underrun_q;

  logic              busy, start_ok, baud_wrap, byte_ready, take;
  logic              load, boundary, bit_nxt;
  logic [7:0]        byte_sel;
  logic [15:0]       pay_last;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  assign busy       = (state_q != S_IDLE);
  assign start_ok   = start_i && !busy && (len_i != 8'd0) && ({1'b0, len_i} <= MAX_LEN9);
  assign baud_wrap  = busy && (baud_q == BAUD_LAST);
  assign byte_ready = ((state_q == S_LEN) || (state_q == S_PAYLOAD)) &&
                      !hold_full_q && (fetch_q < len_q);
  assign take       = byte_valid_i && byte_ready;
  assign pay_last   = {5'd0, len_q, 3'd0} - 16'd1;

  // Bit counter runs down to zero within each state; zero marks the last bit.
  always_comb begin
    state_nxt = state_q;
    bits_nxt  = bits_left_q;
    if (state_q == S_IDLE) begin
      if (start_ok) begin
        state_nxt = S_PREAMBLE;
        bits_nxt  = PRE_LAST;
      end
    end else if (baud_wrap) begin
      if (bits_left_q != 16'd0) begin
        bits_nxt = bits_left_q - 16'd1;
      end else begin
        case (state_q)
          S_PREAMBLE: begin state_nxt = S_SYNC;    bits_nxt = 16'd15;   end
          S_SYNC:     begin state_nxt = S_LEN;     bits_nxt = 16'd7;    end
          S_LEN:      begin state_nxt = S_PAYLOAD; bits_nxt = pay_last; end
          S_PAYLOAD:  begin state_nxt = S_CRC;     bits_nxt = 16'd7;    end
          S_CRC:      begin state_nxt = S_GAP;     bits_nxt = GAP_LAST; end
          default:    begin state_nxt = S_IDLE;    bits_nxt = 16'd0;    end
        endcase
      end
    end
  end

  // A bit position is loaded on every accepted start and on every baud wrap that
  // stays inside the frame. A payload byte boundary is a load of bit 7 of a byte.
  always_comb begin
    load         = start_ok || (baud_wrap && (state_nxt != S_IDLE));
    boundary     = load && (state_nxt == S_PAYLOAD) && (bits_nxt[2:0] == 3'b111);
    byte_sel     = 8'h00;
    if (hold_full_q)
      byte_sel = hold_q;
    else if (take)
      byte_sel = byte_i;
    cur_byte_nxt = boundary ? byte_sel : cur_byte_q;
    bit_nxt      = 1'b0;
    case (state_nxt)
      S_PREAMBLE: bit_nxt = (state_q == S_IDLE) ? 1'b1 : ~data_q;
      S_SYNC:     bit_nxt = SYNC_WORD[bits_nxt[3:0]];
      S_LEN:      bit_nxt = len_q[bits_nxt[2:0]];
      S_PAYLOAD:  bit_nxt = cur_byte_nxt[bits_nxt[2:0]];
      S_CRC:      bit_nxt = crc_q[bits_nxt[2:0]];
      default:    bit_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q      <= '0;
      bits_left_q <= 16'd0;
      len_q       <= 8'd0;
      fetch_q     <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      cur_byte_q  <= 8'd0;
      crc_q       <= 8'd0;
      data_q      <= 1'b0;
      strobe_q    <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      baud_q      <= (start_ok || baud_wrap || !busy) ? '0 : baud_q + BAUD_W'(1);
      bits_left_q <= bits_nxt;
      cur_byte_q  <= cur_byte_nxt;
      strobe_q    <= load;
      done_q      <= baud_wrap && (state_nxt == S_IDLE);
      if (load)
        data_q <= bit_nxt;
      else if (state_nxt == S_IDLE)
        data_q <= 1'b0;

      if (start_ok) begin
        len_q       <= len_i;
        crc_q       <= 8'h00;
        underrun_q  <= 1'b0;
        fetch_q     <= 8'd0;
        hold_full_q <= 1'b0;
      end else begin
        if (load && ((state_nxt == S_LEN) || (state_nxt == S_PAYLOAD)))
          crc_q <= crc8_step(crc_q, bit_nxt);
        if (boundary && !hold_full_q && !take)
          underrun_q <= 1'b1;
        // A byte arriving exactly on its boundary bypasses the holding register.
        if (boundary) begin
          hold_full_q <= 1'b0;
          if (!hold_full_q)
            fetch_q <= fetch_q + 8'd1;
        end else if (take) begin
          hold_q      <= byte_i;
          hold_full_q <= 1'b1;
          fetch_q     <= fetch_q + 8'd1;
        end
      end
    end
  end

  assign start_ready_o = !busy;
  assign tx_active_o   = busy;
  assign byte_ready_o  = byte_ready;
  assign data_o        = data_q;
  assign bit_strobe_o  = strobe_q;
  assign frame_done_o  = done_q;
  assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_frame_transmitter.sv
// Directed bench for frame_transmitter: captures the serial line on each strobe,
// deserializes the frame and compares fields against hand-derived values.
module tb_frame_transmitter;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [7:0] len_i;
  logic       start_ready_o;
  logic [7:0] byte_i;
  logic       byte_valid_i;
  logic       byte_ready_o;
  logic       data_o;
  logic       bit_strobe_o;
  logic       tx_active_o;
  logic       frame_done_o;
  logic       underrun_o;

  always #5 clk = ~clk;

  frame_transmitter #(
    .CLKS_PER_BIT(CPB), .PREAMBLE_BITS(16), .SYNC_WORD(16'hD391),
    .GAP_BITS(8), .MAX_LEN(255)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i),
    .start_ready_o(start_ready_o), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o), .data_o(data_o), .bit_strobe_o(bit_strobe_o),
    .tx_active_o(tx_active_o), .frame_done_o(frame_done_o), .underrun_o(underrun_o)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] pay [256];
  logic [7:0] exp_bytes [$];
  logic       cap [$];
  int strobe_iv_err, stable_err, active_cnt, done_cnt, timeout, first_strobe_ok, underrun_seen;
  int withhold_idx;
  bit rand_valid;
  bit busy_start;

  int nbits, pre_err, gap_err;
  logic [15:0] sync_got;
  logic [7:0]  len_got, crc_got;
  logic [7:0]  got_bytes [256];

  function automatic logic [7:0] crc_ref();
    logic [7:0] c;
    c = 8'h00;
    foreach (exp_bytes[i]) begin
      c = c ^ exp_bytes[i];
      for (int k = 0; k < 8; k++)
        c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  task automatic send_frame(input int len);
    int cyc, feed, last_strobe, limit;
    logic prev;
    bit done;
    cap.delete();
    strobe_iv_err = 0; stable_err = 0; active_cnt = 0; done_cnt = 0;
    timeout = 0; underrun_seen = 0;
    limit = (16 + 16 + 8 + 8*len + 8 + 8) * CPB + 40;
    start_i = 1'b1;
    len_i   = len[7:0];
    @(negedge clk);
    start_i = 1'b0;
    first_strobe_ok = (bit_strobe_o && tx_active_o) ? 1 : 0;
    feed = 0; cyc = 0; last_strobe = -1; prev = data_o; done = 0;
    while (!done) begin
      if (bit_strobe_o) begin
        cap.push_back(data_o);
        if (last_strobe >= 0 && (cyc - last_strobe) != CPB) strobe_iv_err++;
        last_strobe = cyc;
      end else if (data_o !== prev) begin
        stable_err++;
      end
      prev = data_o;
      if (tx_active_o) active_cnt++;
      if (underrun_o) underrun_seen = 1;
      if (frame_done_o) begin
        done_cnt++;
        done = 1;
      end
      if (busy_start) begin
        start_i = (cyc >= 20 && cyc < 40);
        len_i   = 8'd5;
      end
      if (feed == withhold_idx && underrun_o) feed++;
      byte_valid_i = (feed < len) && (feed != withhold_idx) &&
                     (!rand_valid || $urandom_range(0, 3) != 0);
      byte_i = (feed < len) ? pay[feed] : 8'h00;
      if (byte_valid_i && byte_ready_o) feed++;
      if (!done) begin
        cyc++;
        if (cyc > limit) begin
          timeout = 1;
          done = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
    byte_valid_i = 1'b0;
    start_i      = 1'b0;
  endtask

  task automatic decode(input int len);
    int p;
    nbits = cap.size(); pre_err = 0; gap_err = 0;
    sync_got = 'x; len_got = 'x; crc_got = 'x;
    for (int i = 0; i < 256; i++) got_bytes[i] = 'x;
    if (nbits != 16 + 16 + 8 + 8*len + 8 + 8) return;
    for (int i = 0; i < 16; i++)
      if (cap[i] !== (((i % 2) == 0) ? 1'b1 : 1'b0)) pre_err++;
    p = 16;
    for (int i = 0; i < 16; i++) begin sync_got = {sync_got[14:0], cap[p]}; p++; end
    for (int i = 0; i < 8; i++) begin len_got = {len_got[6:0], cap[p]}; p++; end
    for (int b = 0; b < len; b++)
      for (int i = 0; i < 8; i++) begin got_bytes[b] = {got_bytes[b][6:0], cap[p]}; p++; end
    for (int i = 0; i < 8; i++) begin crc_got = {crc_got[6:0], cap[p]}; p++; end
    for (int i = 0; i < 8; i++) begin
      if (cap[p] !== 1'b0) gap_err++;
      p++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (data_o !== 1'b0) begin failures++; $display("FAIL rst_data actual=%b expected=0", data_o); end
    checks++; if (start_ready_o !== 1'b1) begin failures++; $display("FAIL rst_start_ready actual=%b expected=1", start_ready_o); end
    checks++; if ({bit_strobe_o, tx_active_o, frame_done_o, underrun_o, byte_ready_o} !== 5'b0)
      begin failures++; $display("FAIL rst_outputs actual=%b expected=00000",
        {bit_strobe_o, tx_active_o, frame_done_o, underrun_o, byte_ready_o}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    int extra_done, extra_strobe;
    pay[0] = 8'hA5;
    send_frame(1);
    decode(1);
    checks++; if (timeout !== 0) begin failures++; $display("FAIL t1_timeout actual=%0d expected=0", timeout); end
    checks++; if (nbits !== 64) begin failures++; $display("FAIL t1_bits actual=%0d expected=64", nbits); end
    checks++; if (pre_err !== 0) begin failures++; $display("FAIL t1_preamble bad_bits=%0d expected=0", pre_err); end
    checks++; if (sync_got !== 16'hD391) begin failures++; $display("FAIL t1_sync actual=%h expected=d391", sync_got); end
    checks++; if (len_got !== 8'h01) begin failures++; $display("FAIL t1_len actual=%h expected=01", len_got); end
    checks++; if (got_bytes[0] !== 8'hA5) begin failures++; $display("FAIL t1_byte actual=%h expected=a5", got_bytes[0]); end
    checks++; if (crc_got !== 8'h67) begin failures++; $display("FAIL t1_crc actual=%h expected=67", crc_got); end
    checks++; if (gap_err !== 0) begin failures++; $display("FAIL t1_gap bad_bits=%0d expected=0", gap_err); end
    checks++; if (first_strobe_ok !== 1) begin failures++; $display("FAIL t1_first_strobe actual=%0d expected=1", first_strobe_ok); end
    checks++; if (strobe_iv_err !== 0) begin failures++; $display("FAIL t2_strobe_spacing bad=%0d expected=0", strobe_iv_err); end
    checks++; if (stable_err !== 0) begin failures++; $display("FAIL t2_data_stable bad=%0d expected=0", stable_err); end
    checks++; if (active_cnt !== 256) begin failures++; $display("FAIL t2_active_clks actual=%0d expected=256", active_cnt); end
    checks++; if (start_ready_o !== 1'b1) begin failures++; $display("FAIL t1_ready_at_done actual=%b expected=1", start_ready_o); end
    extra_done = 0; extra_strobe = 0;
    repeat (12) begin
      @(negedge clk);
      if (frame_done_o) extra_done++;
      if (bit_strobe_o || tx_active_o || data_o) extra_strobe++;
    end
    checks++; if (done_cnt + extra_done !== 1) begin failures++; $display("FAIL t1_done_pulses actual=%0d expected=1", done_cnt + extra_done); end
    checks++; if (extra_strobe !== 0) begin failures++; $display("FAIL t1_idle_activity actual=%0d expected=0", extra_strobe); end
  endtask

  task automatic test_underrun();
    pay[0] = 8'hB0; pay[1] = 8'hEE; pay[2] = 8'hB2;
    exp_bytes = {8'h03, 8'hB0, 8'h00, 8'hB2};
    withhold_idx = 1;
    send_frame(3);
    withhold_idx = -1;
    decode(3);
    checks++; if (len_got !== 8'h03) begin failures++; $display("FAIL t3_len actual=%h expected=03", len_got); end
    checks++; if (got_bytes[0] !== 8'hB0) begin failures++; $display("FAIL t3_byte0 actual=%h expected=b0", got_bytes[0]); end
    checks++; if (got_bytes[1] !== 8'h00) begin failures++; $display("FAIL t3_byte1 actual=%h expected=00", got_bytes[1]); end
    checks++; if (got_bytes[2] !== 8'hB2) begin failures++; $display("FAIL t3_byte2 actual=%h expected=b2", got_bytes[2]); end
    checks++; if (crc_got !== crc_ref()) begin failures++; $display("FAIL t3_crc actual=%h expected=%h", crc_got, crc_ref()); end
    checks++; if (underrun_o !== 1'b1) begin failures++; $display("FAIL t3_underrun actual=%b expected=1", underrun_o); end
  endtask

  task automatic test_ignored_starts();
    int act;
    act = 0;
    start_i = 1'b1; len_i = 8'd0;
    @(negedge clk);
    start_i = 1'b0;
    repeat (8) begin
      if (tx_active_o || bit_strobe_o || !start_ready_o || data_o) act++;
      @(negedge clk);
    end
    checks++; if (act !== 0) begin failures++; $display("FAIL t4_len0_activity actual=%0d expected=0", act); end
    checks++; if (underrun_o !== 1'b1) begin failures++; $display("FAIL t4_len0_flag actual=%b expected=1", underrun_o); end
    pay[0] = 8'h3C;
    exp_bytes = {8'h01, 8'h3C};
    busy_start = 1'b1;
    send_frame(1);
    busy_start = 1'b0;
    decode(1);
    checks++; if (nbits !== 64) begin failures++; $display("FAIL t4_bits actual=%0d expected=64", nbits); end
    checks++; if (len_got !== 8'h01) begin failures++; $display("FAIL t4_len actual=%h expected=01", len_got); end
    checks++; if (got_bytes[0] !== 8'h3C) begin failures++; $display("FAIL t4_byte actual=%h expected=3c", got_bytes[0]); end
    checks++; if (crc_got !== crc_ref()) begin failures++; $display("FAIL t4_crc actual=%h expected=%h", crc_got, crc_ref()); end
    checks++; if (underrun_o !== 1'b0) begin failures++; $display("FAIL t4_flag_cleared actual=%b expected=0", underrun_o); end
    @(negedge clk);
    checks++; if (tx_active_o !== 1'b0) begin failures++; $display("FAIL t4_no_retrigger actual=%b expected=0", tx_active_o); end
  endtask

  task automatic test_mid_frame_reset();
    start_i = 1'b1; len_i = 8'd4;
    @(negedge clk);
    start_i = 1'b0;
    byte_valid_i = 1'b1; byte_i = 8'hFF;
    repeat (180) @(negedge clk);
    checks++; if ({tx_active_o, data_o} !== 2'b11) begin failures++; $display("FAIL t5_pre_reset actual=%b expected=11", {tx_active_o, data_o}); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (data_o !== 1'b0) begin failures++; $display("FAIL t5_data actual=%b expected=0", data_o); end
    checks++; if (tx_active_o !== 1'b0) begin failures++; $display("FAIL t5_active actual=%b expected=0", tx_active_o); end
    checks++; if (start_ready_o !== 1'b1) begin failures++; $display("FAIL t5_start_ready actual=%b expected=1", start_ready_o); end
    rst = 1'b0; byte_valid_i = 1'b0;
    @(negedge clk);
    pay[0] = 8'h5A; pay[1] = 8'hC3;
    exp_bytes = {8'h02, 8'h5A, 8'hC3};
    send_frame(2);
    decode(2);
    checks++; if (nbits !== 72) begin failures++; $display("FAIL t5_bits actual=%0d expected=72", nbits); end
    checks++; if (sync_got !== 16'hD391) begin failures++; $display("FAIL t5_sync actual=%h expected=d391", sync_got); end
    checks++; if ({got_bytes[0], got_bytes[1]} !== 16'h5AC3) begin failures++; $display("FAIL t5_bytes actual=%h expected=5ac3", {got_bytes[0], got_bytes[1]}); end
    checks++; if (crc_got !== crc_ref()) begin failures++; $display("FAIL t5_crc actual=%h expected=%h", crc_got, crc_ref()); end
    checks++; if (underrun_seen !== 0) begin failures++; $display("FAIL t5_underrun actual=%0d expected=0", underrun_seen); end
  endtask

  task automatic test_back_to_back();
    int bad, first_bad;
    rand_valid = 1'b1;
    for (int f = 0; f < 2; f++) begin
      exp_bytes = {8'hFF};
      for (int i = 0; i < 255; i++) begin
        pay[i] = 8'($urandom_range(0, 255));
        exp_bytes.push_back(pay[i]);
      end
      send_frame(255);
      decode(255);
      bad = 0; first_bad = -1;
      for (int i = 0; i < 255; i++)
        if (got_bytes[i] !== exp_bytes[i+1]) begin
          if (first_bad < 0) first_bad = i;
          bad++;
        end
      checks++; if (timeout !== 0) begin failures++; $display("FAIL t6_timeout frame=%0d actual=%0d expected=0", f, timeout); end
      checks++; if (first_strobe_ok !== 1) begin failures++; $display("FAIL t6_start_latency frame=%0d actual=%0d expected=1", f, first_strobe_ok); end
      checks++; if (sync_got !== 16'hD391) begin failures++; $display("FAIL t6_sync frame=%0d actual=%h expected=d391", f, sync_got); end
      checks++; if (len_got !== 8'hFF) begin failures++; $display("FAIL t6_len frame=%0d actual=%h expected=ff", f, len_got); end
      checks++; if (bad !== 0) begin failures++; $display("FAIL t6_bytes frame=%0d bad=%0d first_idx=%0d expected_bad=0", f, bad, first_bad); end
      checks++; if (crc_got !== crc_ref()) begin failures++; $display("FAIL t6_crc frame=%0d actual=%h expected=%h", f, crc_got, crc_ref()); end
      checks++; if (strobe_iv_err !== 0) begin failures++; $display("FAIL t6_strobe_spacing frame=%0d bad=%0d expected=0", f, strobe_iv_err); end
      checks++; if (underrun_seen !== 0) begin failures++; $display("FAIL t6_underrun frame=%0d actual=%0d expected=0", f, underrun_seen); end
    end
    rand_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; len_i = 8'd0; byte_i = 8'd0; byte_valid_i = 1'b0;
    withhold_idx = -1; rand_valid = 1'b0; busy_start = 1'b0;
    test_reset();
    test_basic_frame();
    test_underrun();
    test_ignored_starts();
    test_mid_frame_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
